// File: rtl/ysyx_25040109_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU data-memory arbiter: FSM states, owner codes,
// store length codes and the default timeout.
package ysyx_25040109_mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W         = 32;
  localparam int unsigned ARB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_IFU = 2'd1,
    ST_GRANT_LSU = 2'd2
  } arb_state_e;

  // Values double as the arb_owner debug output encoding.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_IFU  = 2'b01,
    OWNER_LSU  = 2'b10
  } arb_owner_e;

  localparam logic [2:0] WLEN_B = 3'b001;
  localparam logic [2:0] WLEN_H = 3'b010;
  localparam logic [2:0] WLEN_W = 3'b100;

  // Round-robin pick: on a tie the master that did not finish last wins.
  function automatic arb_owner_e arb_pick(input logic ifu_req, input logic lsu_req,
                                          input arb_owner_e last_owner);
    arb_owner_e pick;
    pick = OWNER_NONE;
    if (ifu_req && lsu_req) begin
      pick = (last_owner == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
    end else if (ifu_req) begin
      pick = OWNER_IFU;
    end else if (lsu_req) begin
      pick = OWNER_LSU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ysyx_25040109_mem_arbiter_watchdog.sv
// Transaction watchdog: cleared while idle, counts waiting cycles, and pulses
// expire_o on the cycle the count reaches TIMEOUT_CYCLES.
module ysyx_25040109_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign expire_o = en_i && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_25040109_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU and LSU.
// Define YSYX_25040109_ARB_TIMEOUT_EN to add forced error completion on slave silence.
module ysyx_25040109_mem_arbiter
  import ysyx_25040109_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = ARB_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_ren,
  input  logic [ADDR_W-1:0] ifu_raddr,
  output logic [ADDR_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  output logic              ifu_err,
  input  logic              lsu_ren,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_raddr,
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [ADDR_W-1:0] lsu_wdata,
  input  logic [2:0]        lsu_wlen,
  output logic [ADDR_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  output logic              lsu_wready,
  output logic              lsu_err,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic [2:0]        mem_wlen,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_wready,
  output logic [1:0]        arb_owner
);

  arb_state_e state_q;
  arb_owner_e last_owner_q;
  arb_owner_e owner_q;
  arb_owner_e pick;

  logic ifu_req;
  logic lsu_req;
  logic grant_ifu;
  logic grant_lsu;
  logic busy;
  logic owner_req;
  logic rd_done;
  logic wr_done;
  logic expire;
  logic timeout_done;
  logic done;

  assign ifu_req = ifu_ren;
  assign lsu_req = lsu_ren | lsu_wen;
  assign pick    = arb_pick(ifu_req, lsu_req, last_owner_q);

  // Grants are masked by rst so the slave port drops while reset is held.
  assign grant_ifu = (state_q == ST_GRANT_IFU) && !rst;
  assign grant_lsu = (state_q == ST_GRANT_LSU) && !rst;
  assign busy      = grant_ifu | grant_lsu;
  assign owner_req = (grant_ifu & ifu_req) | (grant_lsu & lsu_req);

  // A simultaneous LSU read+write is illegal; the write is forwarded.
  assign mem_ren   = (grant_ifu & ifu_ren) | (grant_lsu & lsu_ren & ~lsu_wen);
  assign mem_raddr = grant_ifu ? ifu_raddr : (grant_lsu ? lsu_raddr : '0);
  assign mem_wen   = grant_lsu & lsu_wen;
  assign mem_waddr = grant_lsu ? lsu_waddr : '0;
  assign mem_wdata = grant_lsu ? lsu_wdata : '0;
  assign mem_wlen  = grant_lsu ? lsu_wlen : 3'b000;

  assign rd_done      = mem_ren & mem_rvalid;
  assign wr_done      = mem_wen & mem_wready;
  assign timeout_done = expire & owner_req;
  assign done         = rd_done | wr_done | timeout_done;

`ifdef YSYX_25040109_ARB_TIMEOUT_EN
  ysyx_25040109_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (~busy),
    .en_i    (busy & ~rd_done & ~wr_done),
    .expire_o(expire)
  );

  assign ifu_err = grant_ifu & timeout_done;
  assign lsu_err = grant_lsu & timeout_done;
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

  assign expire  = 1'b0;
  assign ifu_err = 1'b0;
  assign lsu_err = 1'b0;
`endif

  // Responses reach only the owner; rdata is zero outside a real read completion.
  assign ifu_rvalid = grant_ifu & (rd_done | timeout_done);
  assign ifu_rdata  = (grant_ifu & rd_done) ? mem_rdata : '0;
  assign lsu_rvalid = grant_lsu & (rd_done | (timeout_done & ~lsu_wen));
  assign lsu_wready = grant_lsu & (wr_done | (timeout_done & lsu_wen));
  assign lsu_rdata  = (grant_lsu & rd_done) ? mem_rdata : '0;

  assign arb_owner = owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_IFU;
      owner_q      <= OWNER_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick == OWNER_IFU) begin
            state_q <= ST_GRANT_IFU;
            owner_q <= OWNER_IFU;
          end else if (pick == OWNER_LSU) begin
            state_q <= ST_GRANT_LSU;
            owner_q <= OWNER_LSU;
          end
        end
        ST_GRANT_IFU, ST_GRANT_LSU: begin
          if (done) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_NONE;
            last_owner_q <= owner_q;
          end else if (!owner_req) begin
            // Aborted by the master: fairness history is left untouched.
            state_q <= ST_IDLE;
            owner_q <= OWNER_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          owner_q <= OWNER_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_mem_arbiter.sv
// Directed bench for ysyx_25040109_mem_arbiter; follows YSYX_25040109_ARB_TIMEOUT_EN.
module tb_ysyx_25040109_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_ren;
  logic [31:0] ifu_raddr;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_err;
  logic        lsu_ren;
  logic        lsu_wen;
  logic [31:0] lsu_raddr;
  logic [31:0] lsu_waddr;
  logic [31:0] lsu_wdata;
  logic [2:0]  lsu_wlen;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        lsu_wready;
  logic        lsu_err;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_wlen;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wready;
  logic [1:0]  arb_owner;

  int passed;
  int total;

`ifdef YSYX_25040109_ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  ysyx_25040109_mem_arbiter #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_ren   (ifu_ren),
    .ifu_raddr (ifu_raddr),
    .ifu_rdata (ifu_rdata),
    .ifu_rvalid(ifu_rvalid),
    .ifu_err   (ifu_err),
    .lsu_ren   (lsu_ren),
    .lsu_wen   (lsu_wen),
    .lsu_raddr (lsu_raddr),
    .lsu_waddr (lsu_waddr),
    .lsu_wdata (lsu_wdata),
    .lsu_wlen  (lsu_wlen),
    .lsu_rdata (lsu_rdata),
    .lsu_rvalid(lsu_rvalid),
    .lsu_wready(lsu_wready),
    .lsu_err   (lsu_err),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wlen  (mem_wlen),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .mem_wready(mem_wready),
    .arb_owner (arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    ifu_ren    = 1'b0;
    ifu_raddr  = '0;
    lsu_ren    = 1'b0;
    lsu_wen    = 1'b0;
    lsu_raddr  = '0;
    lsu_waddr  = '0;
    lsu_wdata  = '0;
    lsu_wlen   = 3'b000;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    repeat (3) tick();

    check("rst_owner", 32'(arb_owner), 32'h0);
    check("rst_mem_ren", 32'(mem_ren), 32'h0);
    check("rst_mem_wen", 32'(mem_wen), 32'h0);
    check("rst_resp", 32'({ifu_rvalid, lsu_rvalid, lsu_wready, ifu_err, lsu_err}), 32'h0);
    check("rst_rdata", ifu_rdata | lsu_rdata, 32'h0);

    // IFU read, slave answers two cycles after the grant
    rst       = 1'b0;
    ifu_ren   = 1'b1;
    ifu_raddr = 32'h8000_0000;
    #1;
    check("idle_no_mem_ren", 32'(mem_ren), 32'h0);
    tick();
    check("ifu_grant_ren", 32'(mem_ren), 32'h1);
    check("ifu_grant_addr", mem_raddr, 32'h8000_0000);
    check("ifu_grant_owner", 32'(arb_owner), 32'h1);
    tick();
    check("ifu_wait_rvalid", 32'(ifu_rvalid), 32'h0);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0413;
    #1;
    check("ifu_rvalid", 32'(ifu_rvalid), 32'h1);
    check("ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("ifu_lsu_quiet", 32'(lsu_rvalid), 32'h0);
    check("ifu_err_clear", 32'(ifu_err), 32'h0);
    tick();
    ifu_ren    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check("ifu_done_idle", 32'(arb_owner), 32'h0);
    check("ifu_done_mem_ren", 32'(mem_ren), 32'h0);

    // Tie: last owner was IFU, so LSU wins
    ifu_ren   = 1'b1;
    ifu_raddr = 32'h8000_0004;
    lsu_ren   = 1'b1;
    lsu_raddr = 32'h8000_0100;
    tick();
    check("tie1_owner", 32'(arb_owner), 32'h2);
    check("tie1_raddr", mem_raddr, 32'h8000_0100);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    #1;
    check("tie1_lsu_rvalid", 32'(lsu_rvalid), 32'h1);
    check("tie1_lsu_rdata", lsu_rdata, 32'h1111_2222);
    check("tie1_ifu_quiet", 32'(ifu_rvalid), 32'h0);
    check("tie1_ifu_rdata0", ifu_rdata, 32'h0);
    tick();
    mem_rvalid = 1'b0;
    lsu_raddr  = 32'h8000_0200;
    #1;
    check("b2b_idle_gap", 32'(arb_owner), 32'h0);
    // Both still requesting: LSU finished last, so IFU wins
    tick();
    check("tie2_owner", 32'(arb_owner), 32'h1);
    check("tie2_raddr", mem_raddr, 32'h8000_0004);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA_5555;
    #1;
    check("tie2_ifu_rdata", ifu_rdata, 32'hAAAA_5555);
    check("tie2_lsu_quiet", 32'(lsu_rvalid), 32'h0);
    tick();
    ifu_ren    = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    check("lsu_after_ifu", 32'(arb_owner), 32'h2);
    // LSU abandons its read: no strobe, history unchanged
    lsu_ren = 1'b0;
    #1;
    check("abort_mem_ren", 32'(mem_ren), 32'h0);
    check("abort_no_strobe", 32'(lsu_rvalid), 32'h0);
    tick();
    check("abort_idle", 32'(arb_owner), 32'h0);
    ifu_ren = 1'b1;
    lsu_ren = 1'b1;
    tick();
    check("tie3_after_abort", 32'(arb_owner), 32'h2);
    ifu_ren = 1'b0;
    lsu_ren = 1'b0;
    tick();

    // LSU word write, zero-wait slave
    lsu_wen   = 1'b1;
    lsu_waddr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wlen  = 3'b100;
    tick();
    mem_wready = 1'b1;
    #1;
    check("wr_mem_wen", 32'(mem_wen), 32'h1);
    check("wr_waddr", mem_waddr, 32'h8000_1000);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_wlen", 32'(mem_wlen), 32'h4);
    check("wr_no_ren", 32'(mem_ren), 32'h0);
    check("wr_wready", 32'(lsu_wready), 32'h1);
    check("wr_err_clear", 32'(lsu_err), 32'h0);
    tick();
    lsu_wen    = 1'b0;
    mem_wready = 1'b0;
    #1;
    check("wr_idle", 32'(arb_owner), 32'h0);

    // Illegal read+write: the write wins
    lsu_ren   = 1'b1;
    lsu_wen   = 1'b1;
    lsu_waddr = 32'h8000_2000;
    lsu_wlen  = 3'b001;
    tick();
    check("rw_mem_ren", 32'(mem_ren), 32'h0);
    check("rw_mem_wen", 32'(mem_wen), 32'h1);
    mem_wready = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    check("rw_wready", 32'(lsu_wready), 32'h1);
    check("rw_no_rvalid", 32'(lsu_rvalid), 32'h0);
    tick();
    lsu_ren    = 1'b0;
    lsu_wen    = 1'b0;
    mem_wready = 1'b0;
    mem_rvalid = 1'b0;
    tick();

    // Reset in the middle of an LSU read, late slave strobe afterwards
    lsu_ren   = 1'b1;
    lsu_raddr = 32'h8000_3000;
    tick();
    check("mid_rst_grant", 32'(mem_ren), 32'h1);
    rst = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    #1;
    check("mid_rst_owner", 32'(arb_owner), 32'h0);
    check("mid_rst_mem_ren", 32'(mem_ren), 32'h0);
    check("mid_rst_no_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 32'h0);
    rst        = 1'b0;
    lsu_ren    = 1'b0;
    mem_rvalid = 1'b0;
    tick();

    // Silent slave on an IFU read
    mem_rdata = 32'h1234_5678;
    ifu_ren   = 1'b1;
    ifu_raddr = 32'h8000_0040;
`ifdef YSYX_25040109_ARB_TIMEOUT_EN
    tick();
    check("to_cyc1", 32'(ifu_rvalid), 32'h0);
    tick();
    check("to_cyc2", 32'(ifu_rvalid), 32'h0);
    tick();
    check("to_cyc3", 32'(ifu_rvalid), 32'h0);
    tick();
    check("to_rvalid", 32'(ifu_rvalid), 32'h1);
    check("to_err", 32'(ifu_err), 32'h1);
    check("to_rdata", ifu_rdata, 32'h0);
    check("to_lsu_quiet", 32'({lsu_rvalid, lsu_err}), 32'h0);
    tick();
    ifu_ren = 1'b0;
    #1;
    check("to_idle", 32'(arb_owner), 32'h0);
`else
    repeat (301) tick();
    check("nto_still_owner", 32'(arb_owner), 32'h1);
    check("nto_still_ren", 32'(mem_ren), 32'h1);
    check("nto_no_rvalid", 32'(ifu_rvalid), 32'h0);
    check("nto_no_err", 32'(ifu_err), 32'h0);
    ifu_ren = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
